// File: rtl/pb_event_decoder_if.sv
// ---------------------------------------------------------------------------
// pb_event_decoder_if
//
// Purpose: bundles the push-button level input and the decoded event outputs
// of pb_event_decoder so they can be passed around as one port.
//
// Signals (all 1 bit, synchronous to the decoder clock):
//   state         debounced button level, 1 = pressed
//   press         one-cycle pulse when a press is recognised
//   release_pulse one-cycle pulse on every release. The plain name "release"
//                 is a SystemVerilog keyword, so it cannot be used here.
//   click         one-cycle pulse on a release before the long-press threshold
//   long_press    one-cycle pulse when the hold reaches the threshold
//   repeat_pulse  one-cycle auto-repeat pulse. The plain name "repeat" is
//                 also a keyword.
//   held          level, high while a press is in progress
//
// Modports:
//   slave  - the decoder: reads state and drives the event outputs
//   master - the button side / consumer: drives state and reads the events
//
// Handshake: none. state is sampled on every rising edge, and every event
// output is a registered, single-cycle pulse.
// ---------------------------------------------------------------------------
interface pb_event_decoder_if;
    logic state;
    logic press;
    logic release_pulse;
    logic click;
    logic long_press;
    logic repeat_pulse;
    logic held;

    modport slave (
        input  state,
        output press,
        output release_pulse,
        output click,
        output long_press,
        output repeat_pulse,
        output held
    );

    modport master (
        output state,
        input  press,
        input  release_pulse,
        input  click,
        input  long_press,
        input  repeat_pulse,
        input  held
    );
endinterface

// File: rtl/pb_event_decoder.sv
// ---------------------------------------------------------------------------
// pb_event_decoder
//
// Purpose: turns a debounced button level into press / release / click /
// long-press events, with optional auto-repeat while the button is held long.
//
// Optional feature: define PB_AUTOREPEAT_EN to enable the auto-repeat counter
// and the repeat pulse. Without it, repeat_pulse is tied to 0.
//
// Parameters:
//   CNT_W         width of the hold and repeat counters
//   LONG_THRESH   held cycles after press before long_press (2..2^CNT_W-1)
//   REPEAT_PERIOD cycles between repeat pulses (2..2^CNT_W-1)
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   bus        pb_event_decoder_if.slave (state in, events out)
//   fsm_state  current FSM state encoding: 0 IDLE, 1 PRESSED, 2 LONG_HELD
//
// Timing: an edge that samples state=1 in IDLE registers press for the
// following cycle. long_press follows press by exactly LONG_THRESH cycles.
// The first repeat follows long_press by REPEAT_PERIOD cycles.
// A release sampled on a threshold or repeat-due edge wins over that event.
// ---------------------------------------------------------------------------
module pb_event_decoder #(
    parameter int CNT_W         = 26,
    parameter int LONG_THRESH   = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    pb_event_decoder_if.slave bus,
    output logic [1:0]        fsm_state
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } fsm_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_THRESH - 1);

    localparam bit PARAMS_OK = (CNT_W >= 2) && (CNT_W <= 31) &&
                               (LONG_THRESH >= 2) && (REPEAT_PERIOD >= 2) &&
                               (LONG_THRESH < (1 << CNT_W)) &&
                               (REPEAT_PERIOD < (1 << CNT_W));

    // Reject configurations whose thresholds do not fit the counters.
    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("pb_event_decoder: LONG_THRESH/REPEAT_PERIOD out of range for CNT_W");
        end
    endgenerate

    fsm_t             fsm;
    logic [CNT_W-1:0] hold_cnt;

`ifdef PB_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic [CNT_W-1:0] rpt_cnt;
`else
    assign bus.repeat_pulse = 1'b0;
`endif

    assign fsm_state = fsm;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm            <= IDLE;
            hold_cnt       <= '0;
            bus.press      <= 1'b0;
            bus.release_pulse <= 1'b0;
            bus.click      <= 1'b0;
            bus.long_press <= 1'b0;
            bus.held       <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
            rpt_cnt          <= '0;
            bus.repeat_pulse <= 1'b0;
`endif
        end else begin
            // Pulses default low, so each one lasts a single cycle.
            bus.press         <= 1'b0;
            bus.release_pulse <= 1'b0;
            bus.click         <= 1'b0;
            bus.long_press    <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
            bus.repeat_pulse  <= 1'b0;
`endif
            case (fsm)
                IDLE: begin
                    if (bus.state) begin
                        fsm       <= PRESSED;
                        hold_cnt  <= '0;
                        bus.press <= 1'b1;
                        bus.held  <= 1'b1;
                    end
                end
                PRESSED: begin
                    // A release is checked first, so it also wins on the threshold edge.
                    if (!bus.state) begin
                        fsm               <= IDLE;
                        bus.release_pulse <= 1'b1;
                        bus.click         <= 1'b1;
                        bus.held          <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        fsm            <= LONG_HELD;
                        bus.long_press <= 1'b1;
`ifdef PB_AUTOREPEAT_EN
                        rpt_cnt        <= '0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (!bus.state) begin
                        fsm               <= IDLE;
                        bus.release_pulse <= 1'b1;
                        bus.held          <= 1'b0;
                    end
`ifdef PB_AUTOREPEAT_EN
                    else if (rpt_cnt == RPT_LAST) begin
                        bus.repeat_pulse <= 1'b1;
                        rpt_cnt          <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    fsm      <= IDLE;
                    bus.held <= 1'b0;
                end
            endcase
        end
    end
endmodule
